data_memory_be: RTL
===================

# data_memory_be

Parametrised single-clock data memory for the processor datapath, next generation of the basic synchronous data memory. It adds power-of-two depth from an address-width parameter, per-byte write enables, a registered read with a valid strobe, write-to-read forwarding on address collision, and a post-reset sweep that zeroes every word before the processor may access the memory. It sits between the execute/memory stage and the load/store logic.

## Interface
- WIDTH_DATA, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH words
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- read_enable  input  1  read request, sampled at clk rising edge
- write_enable  input  1  write request, sampled at clk rising edge
- byte_en  input  WIDTH_DATA/8  write byte lanes; bit i selects data_in[8i+7:8i]
- address  input  ADDR_WIDTH  word address, shared by read and write
- data_in  input  WIDTH_DATA  write data
- data_out  output  WIDTH_DATA  registered read data; holds its value between reads
- read_valid  output  1  one-cycle pulse: data_out updated this cycle
- ready  output  1  high when requests are accepted (init sweep done)

## Operation
- FSM states: INIT, READY.
- rst_n low: state <= INIT, sweep counter <= 0, data_out <= 0, read_valid <= 0, ready <= 0. Memory array contents are not reset directly.
- INIT: each rising edge writes all-zero to mem[counter], counter increments. The edge writing address 2**ADDR_WIDTH-1 moves state to READY and sets ready <= 1. Counter is ADDR_WIDTH+1 bits or equivalent so terminal detection does not wrap early.
- INIT: read_enable/write_enable ignored; no memory write from ports, read_valid stays 0, data_out holds.
- READY, write_enable=1: for each lane i with byte_en[i]=1, mem[address] lane i <= data_in lane i; other lanes unchanged. write_enable with byte_en=0 is a no-op.
- READY, read_enable=1: data_out <= mem[address], read_valid <= 1 for one cycle. Otherwise read_valid <= 0, data_out holds.
- Read and write in the same cycle (same address): both are performed. data_out returns forwarded data: lanes with byte_en=1 take data_in, remaining lanes take stored data (write-first).
- ready stays 1 until the next rst_n assertion.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT with reset values above; the sweep restarts from address 0 after release.

## Timing
- Reset to outputs: asynchronous, no clock required.
- Init latency: ready rises after exactly 2**ADDR_WIDTH rising edges with rst_n high (32 edges at defaults).
- Read latency: 1 cycle; request sampled at edge N, data_out/read_valid valid after edge N, read_valid low after edge N+1 unless another read.
- Write latency: written data visible to a read sampled at the same edge (forwarding) and all later edges.
- Back-to-back reads/writes every cycle supported; no stall or backpressure other than ready.

## Test plan
- Reset then idle: after rst_n release, ready=0 for 31 edges, 1 after edge 32; read every address -> data_out=0x00000000, read_valid pulses once per read.
- Full write/read: write 0xDEAD0000+addr with byte_en=4'hF to all 32 addresses, read back -> exact values, read_valid 1 cycle after each request.
- Byte lanes: write 0x11223344 (byte_en=F) to addr 7, then 0xAABBCCDD with byte_en=4'b0101 -> read addr 7 returns 0x11BB33DD.
- Collision: addr 3 holds 0x00000000; same cycle write 0xCAFEF00D byte_en=4'b1100 and read addr 3 -> data_out=0xCAFE0000 next cycle; later read -> 0xCAFE0000.
- Requests during INIT: drive write 0xFFFFFFFF to addr 0 and reads at edges 1-10 after reset -> no read_valid, addr 0 reads 0 after ready.
- Reset mid-sweep and mid-read: assert rst_n at edge 10 of INIT and again during a read -> outputs go 0 asynchronously; ready returns after a full 32-edge sweep.

Source files
------------

// File: rtl/data_memory_be.sv
// data_memory_be: byte-enable data memory with registered read, write-first forwarding
// and a post-reset zeroing sweep that gates access through ready.
module data_memory_be #(
  parameter int WIDTH_DATA = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic [WIDTH_DATA/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [WIDTH_DATA-1:0]   data_in,
  output logic [WIDTH_DATA-1:0]   data_out,
  output logic                    read_valid,
  output logic                    ready
);
  localparam int LANES = WIDTH_DATA / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] cnt;
  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [WIDTH_DATA-1:0] merged;
  logic [WIDTH_DATA-1:0] rd_word;
  logic [WIDTH_DATA-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_we;
  logic last;
  logic rd_go;
  // merged is the post-write word, so it doubles as the forwarded read value
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = byte_en[i] ? data_in[8*i +: 8] : mem[address][8*i +: 8];
  end
  always_comb begin
    last = cnt == (ADDR_WIDTH+1)'(DEPTH - 1);
    state_nx = (state == INIT && last) ? READY : state;
    rd_go = state == READY && read_enable;
    rd_word = write_enable ? merged : mem[address];
    mem_we = state == INIT || (write_enable && |byte_en);
    mem_addr = state == INIT ? cnt[ADDR_WIDTH-1:0] : address;
    mem_wdata = state == INIT ? '0 : merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      data_out <= '0;
      read_valid <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == INIT ? cnt + 1'b1 : cnt;
      ready <= state_nx == READY;
      read_valid <= rd_go;
      data_out <= rd_go ? rd_word : data_out;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
endmodule
